data_mem_multi_port: RTL
========================

DATA_MEM_MULTI_PORT -- requirements
Module: data_mem_multi_port

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, meaning address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter NUM_READ, default 2, range 1..8, meaning number of independent read ports.
REQ-004 SHALL have parameter FORWARD, default 1, meaning 1 = write-to-read forwarding enabled, 0 = old data returned.
REQ-005 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port addr_r  in  NUM_READ*ADDR_WIDTH  read addresses; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 SHALL have port re  in  NUM_READ  per-port read enable.
REQ-009 SHALL have port addr_w  in  ADDR_WIDTH  write address.
REQ-010 SHALL have port data_in  in  DATA_WIDTH  write data.
REQ-011 SHALL have port we  in  1  write enable.
REQ-012 SHALL have port clear_req  in  1  one-cycle pulse requesting a full-memory zero fill.
REQ-013 SHALL have port data_out  out  NUM_READ*DATA_WIDTH  registered read data; port k at [k*DATA_WIDTH +: DATA_WIDTH].
REQ-014 SHALL have port valid_out  out  NUM_READ  per-port flag: data_out slice k updated this cycle.
REQ-015 SHALL have port busy  out  1  high while zero fill in progress.

Function
REQ-016 Every write SHALL be broadcast to all NUM_READ banks so all banks hold identical contents.
REQ-017 Read latency SHALL be exactly 1 cycle: re[k] at edge N -> data_out slice k and valid_out[k]=1 after edge N+1.
REQ-018 With re[k]=0, data_out slice k SHALL hold its previous value and valid_out[k] SHALL be 0.
REQ-019 With FORWARD=1, same-cycle we=1 and addr_w == addr_r slice k SHALL return data_in on port k; with FORWARD=0 it SHALL return the pre-write content.
REQ-020 Fill FSM SHALL have states IDLE and CLEAR; IDLE->CLEAR on clear_req or on reset release; CLEAR->IDLE after the write to address DEPTH-1.
REQ-021 In CLEAR, an ADDR_WIDTH-bit counter SHALL start at 0, write 0 to its address in all banks, increment by 1 per cycle; fill takes exactly DEPTH cycles.
REQ-022 busy SHALL be 1 for every cycle the FSM is in CLEAR and 0 in IDLE.
REQ-023 While busy=1, user we SHALL be ignored (write dropped) and re SHALL be ignored (valid_out=0, data_out held).
REQ-024 clear_req while busy=1 SHALL be ignored (no counter restart).
REQ-025 Simultaneous we and clear_req in IDLE: the write SHALL be performed that cycle, CLEAR begins next cycle and overwrites it.
REQ-026 Counter wrap at DEPTH-1 SHALL terminate the fill; counter SHALL not re-enter 0 as a fill address.

Reset
REQ-027 reset=1 SHALL asynchronously force data_out=0, valid_out=0, fill counter=0, FSM=CLEAR, busy=1.
REQ-028 Memory array contents SHALL not be reset directly; zeroing SHALL occur only via the fill FSM.
REQ-029 Reset asserted mid-fill SHALL restart the fill at address 0 after release.

Structure
REQ-030 FSM state encodings and the NUM_READ upper bound SHALL reside in the shared constants header.
REQ-031 One sub-module data_mem_bank (one write port, one registered read port, DATA_WIDTH/ADDR_WIDTH parameters) SHALL be instantiated NUM_READ times via generate.
REQ-032 Forwarding compare, valid flags and fill FSM SHALL live in the top module, not the bank.

Verification
REQ-033 Reset release, DEPTH=16 -> busy=1 for exactly 16 cycles, then reading every address on every port returns 0.
REQ-034 IDLE, write 0xA5 to addr 3, next cycle re on ports 0,1 at addr 3 -> both return 0xA5 one cycle later with valid_out=2'b11.
REQ-035 FORWARD=1: we=1, addr_w=5, data_in=0x3C, re[0]=1, addr_r0=5 same cycle -> data_out0=0x3C next cycle; FORWARD=0 -> prior value 0x00.
REQ-036 clear_req with we=1 addr 7 data 0x11 same cycle, plus clear_req again at fill cycle 4 -> fill lasts exactly DEPTH cycles; addr 7 reads 0x00 afterwards.
REQ-037 we=1 addr 2 data 0xFF and re=1 during busy -> write dropped (addr 2 reads 0 after fill), valid_out stays 0.
REQ-038 reset pulse at fill cycle 8 -> outputs cleared immediately, fill restarts at 0 and lasts a full DEPTH cycles.

Source files
------------

// File: rtl/data_mem_multi_port_pkg.sv
// Shared constants for the multi-port data memory: fill FSM encoding and port limits.
package data_mem_multi_port_pkg;

  localparam int MAX_NUM_READ = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fill_state_t;

endpackage

// File: rtl/data_mem_multi_port_data_mem_bank.sv
// One memory bank: a single write port and one registered read port with an external bypass select.
module data_mem_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr_w,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr_r,
  input  logic                  fwd,
  output logic [DATA_WIDTH-1:0] data_out
);

  // Array is never reset; zeroing comes only from the fill sequence in the top.
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr_w] <= data_in;
  end

  // ---- stage p1: registered read, held while re is low ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     data_out <= '0;
    else if (re) data_out <= fwd ? data_in : mem[addr_r];
  end

endmodule

// File: rtl/data_mem_multi_port.sv
// Replicated-bank memory with NUM_READ read ports, optional write forwarding and a zero-fill FSM.
module data_mem_multi_port
  import data_mem_multi_port_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_READ   = 2,
  parameter int FORWARD    = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] addr_r,
  input  logic [NUM_READ-1:0]            re,
  input  logic [ADDR_WIDTH-1:0]          addr_w,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic                           we,
  input  logic                           clear_req,
  output logic [NUM_READ*DATA_WIDTH-1:0] data_out,
  output logic [NUM_READ-1:0]            valid_out,
  output logic                           busy
);

  if (NUM_READ < 1 || NUM_READ > MAX_NUM_READ) begin : g_bad_num_read
    $error("data_mem_multi_port: NUM_READ out of range");
  end

  fill_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [NUM_READ-1:0]   re_p0;
  logic [NUM_READ-1:0]   fwd_p0;
  logic [NUM_READ-1:0]   vld_p1;

  // Reset parks the FSM in CLEAR so every release starts a fresh fill from address 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {ADDR_WIDTH{1'b1}}) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == CLEAR);

  // ---- stage p0: arbitrate write source and qualify reads ----
  assign mem_we   = busy | we;
  assign mem_addr = busy ? cnt_q : addr_w;
  assign mem_data = busy ? '0 : data_in;
  assign re_p0    = busy ? '0 : re;

  // ---- stage p1: per-port valid flags ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p1 <= '0;
    else       vld_p1 <= re_p0;
  end

  assign valid_out = vld_p1;

  for (genvar k = 0; k < NUM_READ; k++) begin : g_bank
    assign fwd_p0[k] = (FORWARD != 0) && we && (addr_w == addr_r[k*ADDR_WIDTH +: ADDR_WIDTH]);

    data_mem_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bank (
      .clk     (clk),
      .rst     (reset),
      .we      (mem_we),
      .addr_w  (mem_addr),
      .data_in (mem_data),
      .re      (re_p0[k]),
      .addr_r  (addr_r[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .fwd     (fwd_p0[k]),
      .data_out(data_out[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule
